// File: rtl/gj_inverse_sequencer.sv
// gj_inverse_sequencer
//   Gauss-Jordan elimination sequencer for the N x N matrix-inverse datapath.
//   Walks the augmented matrix [A | I] pivot by pivot and issues one command
//   at a time (RECIP, SCALE, LOADF, ELIM) to the shared arithmetic unit,
//   waiting for each result before issuing the next. A zero pivot aborts.
//
//   Optional feature: define GJ_SEQ_PERF_EN to add the cycle_cnt output.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : synchronous, active-low
//   start      : begin an inversion (sampled only when idle)
//   busy       : run in progress (ISSUE/WAIT)
//   done       : one-cycle pulse at end of run (normal or singular)
//   singular   : sticky zero-pivot flag, cleared on accepted start
//   op_valid   : command valid
//   op_ready   : datapath accepts command
//   op_code    : 0=RECIP 1=SCALE 2=LOADF 3=ELIM
//   op_piv     : pivot index p
//   op_row     : target row
//   op_col     : target column
//   res_valid  : datapath finished the accepted command
//   piv_zero   : with res_valid of a RECIP, the pivot was zero
//   cycle_cnt  : (GJ_SEQ_PERF_EN only) saturating count of run cycles
module gj_inverse_sequencer #(
    parameter int N  = 5,
    parameter int RW = 3,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          singular,
    output logic          op_valid,
    input  logic          op_ready,
    output logic [1:0]    op_code,
    output logic [RW-1:0] op_piv,
    output logic [RW-1:0] op_row,
    output logic [CW-1:0] op_col,
    input  logic          res_valid,
    input  logic          piv_zero
`ifdef GJ_SEQ_PERF_EN
    ,
    output logic [15:0]   cycle_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FIN
    } state_t;

    typedef enum logic [1:0] {
        OP_RECIP = 2'd0,
        OP_SCALE = 2'd1,
        OP_LOADF = 2'd2,
        OP_ELIM  = 2'd3
    } op_t;

    localparam logic [CW-1:0] LAST_COL = CW'(2 * N - 1);
    localparam logic [RW-1:0] LAST_PIV = RW'(N - 1);

    state_t        state_q, state_d;
    op_t           code_q, code_d;
    logic [RW-1:0] piv_q, piv_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          sing_q, sing_d;

    // One extra bit so the "past the last row" test cannot wrap.
    logic [RW:0]   row_inc;
    logic [RW:0]   row_nxt;
    logic          rows_done;
    logic          last_col;
    logic          last_op;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        piv_d   = piv_q;
        row_d   = row_q;
        col_d   = col_q;
        sing_d  = sing_q;

        // Next elimination row skips the pivot row itself.
        row_inc   = {1'b0, row_q} + (RW+1)'(1);
        row_nxt   = (row_inc == {1'b0, piv_q}) ? row_inc + (RW+1)'(1) : row_inc;
        rows_done = (row_nxt >= (RW+1)'(N));
        last_col  = (col_q == LAST_COL);
        last_op   = (code_q == OP_ELIM) && last_col && rows_done && (piv_q == LAST_PIV);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    code_d  = OP_RECIP;
                    piv_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                    sing_d  = 1'b0;
                end
            end
            S_ISSUE: begin
                if (op_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (res_valid) begin
                    if ((code_q == OP_RECIP) && piv_zero) begin
                        sing_d  = 1'b1;
                        state_d = S_FIN;
                    end else if (last_op) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_ISSUE;
                        unique case (code_q)
                            // RECIP already carries row=col=p, which SCALE starts from.
                            OP_RECIP: code_d = OP_SCALE;
                            OP_SCALE: begin
                                if (last_col) begin
                                    code_d = OP_LOADF;
                                    row_d  = (piv_q == '0) ? RW'(1) : '0;
                                    col_d  = CW'(piv_q);
                                end else begin
                                    col_d = col_q + CW'(1);
                                end
                            end
                            // LOADF holds col=p, which is where ELIM starts.
                            OP_LOADF: code_d = OP_ELIM;
                            OP_ELIM: begin
                                if (!last_col) begin
                                    col_d = col_q + CW'(1);
                                end else if (!rows_done) begin
                                    code_d = OP_LOADF;
                                    row_d  = row_nxt[RW-1:0];
                                    col_d  = CW'(piv_q);
                                end else begin
                                    code_d = OP_RECIP;
                                    piv_d  = piv_q + RW'(1);
                                    row_d  = piv_q + RW'(1);
                                    col_d  = CW'(piv_q + RW'(1));
                                end
                            end
                            default: code_d = code_q;
                        endcase
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            code_q  <= OP_RECIP;
            piv_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            sing_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            piv_q   <= piv_d;
            row_q   <= row_d;
            col_q   <= col_d;
            sing_q  <= sing_d;
        end
    end

    assign busy     = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign done     = (state_q == S_FIN);
    assign op_valid = (state_q == S_ISSUE);
    assign op_code  = code_q;
    assign op_piv   = piv_q;
    assign op_row   = row_q;
    assign op_col   = col_q;
    assign singular = sing_q;

`ifdef GJ_SEQ_PERF_EN
    // Counts every cycle of the run from the first command through FIN,
    // so a zero-wait N=5 run reads 2*225 + 1.
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if ((state_q == S_IDLE) && start) begin
            cnt_q <= '0;
        end else if ((state_q != S_IDLE) && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign cycle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_gj_inverse_sequencer.sv
// tb_gj_inverse_sequencer
//   Scoreboard bench for gj_inverse_sequencer (N=5). At each start the
//   expected command sequence is pushed into a queue; each handshake pops
//   and compares. A datapath responder returns res_valid one cycle after
//   accept, with optional stall, zero pivot, mid-run reset and stray start.
module tb_gj_inverse_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        singular;
    logic        op_valid;
    logic        op_ready;
    logic [1:0]  op_code;
    logic [2:0]  op_piv;
    logic [2:0]  op_row;
    logic [3:0]  op_col;
    logic        res_valid;
    logic        piv_zero;
`ifdef GJ_SEQ_PERF_EN
    logic [15:0] cycle_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [11:0] sb_q[$];

    always #5 clk = ~clk;

    gj_inverse_sequencer #(.N(5), .RW(3), .CW(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .singular (singular),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_code  (op_code),
        .op_piv   (op_piv),
        .op_row   (op_row),
        .op_col   (op_col),
        .res_valid(res_valid),
        .piv_zero (piv_zero)
`ifdef GJ_SEQ_PERF_EN
        ,
        .cycle_cnt(cycle_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] pack(input int code, input int p, input int r, input int c);
        return {code[1:0], p[2:0], r[2:0], c[3:0]};
    endfunction

    // Reference op order for a full N=5 run.
    task automatic push_run();
        for (int p = 0; p < 5; p++) begin
            sb_q.push_back(pack(0, p, p, p));
            for (int c = p; c < 10; c++) sb_q.push_back(pack(1, p, p, c));
            for (int r = 0; r < 5; r++) begin
                if (r != p) begin
                    sb_q.push_back(pack(2, p, r, p));
                    for (int c = p; c < 10; c++) sb_q.push_back(pack(3, p, r, c));
                end
            end
        end
    endtask

    task automatic run_case(input int stall_hs, input int zero_p, input int rst_hs,
                            input int start_w_hs, input int start_i_hs,
                            input int exp_hs, input int exp_sing);
        int hs = 0;
        int dones = 0;
        int stall_left = 5;
        bit pending = 0;
        bit pend_recip = 0;
        int pend_piv = 0;
        bit finished = 0;
        bit aborted = 0;
        bit expect_done = 0;
        logic [11:0] exp_op;

        sb_q.delete();
        push_run();
        @(negedge clk);
        start = 1'b1;
        op_ready = 1'b1;
        res_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("valid_after_start", op_valid, 1);
        check("sing_cleared", singular, 0);

        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            res_valid = 1'b0;
            piv_zero = 1'b0;
            op_ready = 1'b1;
            start = 1'b0;
            if (expect_done) begin
                check("done_after_last_res", done, 1);
                expect_done = 0;
            end
            if (done) begin
                dones++;
                check("fin_busy", busy, 0);
                check("fin_singular", singular, exp_sing);
                finished = 1;
            end else if (rst_hs >= 0 && hs == rst_hs) begin
                reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                check("rst_busy", busy, 0);
                check("rst_valid", op_valid, 0);
                check("rst_done", done, 0);
                check("rst_sing", singular, 0);
                check("rst_fields", {op_code, op_piv, op_row, op_col}, 0);
                finished = 1;
                aborted = 1;
            end else if (pending) begin
                check("wait_valid", op_valid, 0);
                check("wait_busy", busy, 1);
                res_valid = 1'b1;
                piv_zero = pend_recip && (pend_piv == zero_p);
                if (piv_zero || (zero_p < 0 && sb_q.size() == 0)) expect_done = 1;
                if (hs == start_w_hs) start = 1'b1;
                pending = 0;
            end else if (op_valid) begin
                if (hs == stall_hs && stall_left > 0) begin
                    op_ready = 1'b0;
                    check("stall_fields", {op_code, op_piv, op_row, op_col},
                          sb_q.size() > 0 ? sb_q[0] : 12'hfff);
                    stall_left--;
                end else begin
                    if (hs == start_i_hs) start = 1'b1;
                    if (sb_q.size() == 0) begin
                        check("sb_underflow", 1, 0);
                    end else begin
                        exp_op = sb_q.pop_front();
                        check($sformatf("op_%0d", hs), {op_code, op_piv, op_row, op_col}, exp_op);
                    end
                    pend_recip = (op_code == 2'd0);
                    pend_piv = int'(op_piv);
                    pending = 1;
                    hs++;
                end
            end
            if (!finished) @(negedge clk);
        end

        if (!finished) begin
            check("timeout", 0, 1);
        end else if (!aborted) begin
            @(negedge clk);
            check("done_single_pulse", done, 0);
            check("idle_valid", op_valid, 0);
            check("idle_busy", busy, 0);
            check("idle_singular", singular, exp_sing);
`ifdef GJ_SEQ_PERF_EN
            if (stall_hs < 0 && zero_p < 0 && start_w_hs < 0 && start_i_hs < 0)
                check("cycle_cnt", cycle_cnt, 2 * 225 + 1);
`endif
            check("hs_count", hs, exp_hs);
            check("done_count", dones, 1);
            if (exp_sing == 0) check("sb_left", sb_q.size(), 0);
        end
        sb_q.delete();
        start = 1'b0;
        res_valid = 1'b0;
        piv_zero = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        op_ready = 1'b0;
        res_valid = 1'b0;
        piv_zero = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_sing", singular, 0);
        check("reset_valid", op_valid, 0);
        check("reset_fields", {op_code, op_piv, op_row, op_col}, 0);
`ifdef GJ_SEQ_PERF_EN
        check("reset_cnt", cycle_cnt, 0);
`endif
        reset = 1'b1;

        // Mid-run reset after 37 handshakes.
        run_case(-1, -1, 37, -1, -1, 0, 0);
        // Zero-wait nonsingular run.
        run_case(-1, -1, -1, -1, -1, 225, 0);
        // Backpressure on SCALE(0,3), stray start in WAIT and in ISSUE.
        run_case(4, -1, -1, 10, 20, 225, 0);
        // Zero pivot at p=2: 55 + 50 + 1 commands issued.
        run_case(-1, 2, -1, -1, -1, 106, 1);
        // Following run clears singular and completes normally.
        run_case(-1, -1, -1, -1, -1, 225, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
